// File: rtl/skolem_chk_pkg.sv
// rtl/skolem_chk_pkg.sv - shared types and the xor_6_2 spec predicate for the Skolem sweep checker
package skolem_chk_pkg;

  localparam int N_IN_DEF = 6;
  localparam int NUM_VEC  = 2 ** N_IN_DEF;
  // Predicate input is zero-extended to this width so one function serves any N_IN.
  localparam int X_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic spec_xor_ok(input logic [X_MAX_W-1:0] x, input logic [1:0] y);
    return (y[0] ^ y[1]) == ~(^x);
  endfunction

endpackage

// File: rtl/skolem_vec_gen.sv
// rtl/skolem_vec_gen.sv - input-assignment counter with per-vector settle delay
module skolem_vec_gen #(
  parameter int N_IN          = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear_x,
  input  logic            run,
  input  logic            advance,
  output logic [N_IN-1:0] x_o,
  output logic            vec_last,
  output logic            eval_en
);

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  logic [3:0] settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_o        <= '0;
      settle_cnt <= '0;
    end else if (clear_x) begin
      x_o <= '0;
    end else if (load) begin
      x_o        <= '0;
      settle_cnt <= SETTLE_RELOAD;
    end else if (run) begin
      if (settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else if (advance) begin
        x_o        <= x_o + N_IN'(1);
        settle_cnt <= SETTLE_RELOAD;
      end
    end
  end

  assign eval_en  = run && (settle_cnt == 4'd0);
  assign vec_last = &x_o;

endmodule

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive sweep of a Skolem block against the xor spec formula
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int N_IN          = 6,
  parameter int N_OUT         = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  x_o,
  input  logic [N_OUT-1:0] y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_cnt,
  output logic             cex_valid,
  output logic [N_IN-1:0]  cex_x,
  output logic [N_OUT-1:0] cex_y
);

  state_t        state, state_nxt;
  logic          load, clear_x, run, advance, terminate;
  logic          eval_en, vec_last, ok;
  logic [N_IN:0] fail_nxt;

  assign run      = (state == SAMPLE);
  assign ok       = spec_xor_ok(X_MAX_W'(x_o), y_i);
  assign fail_nxt = fail_cnt + {{N_IN{1'b0}}, ~ok};
  assign busy     = (state == SAMPLE);
  assign done     = (state == DONE);

  skolem_vec_gen #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_vec_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .clear_x  (clear_x),
    .run      (run),
    .advance  (advance),
    .x_o      (x_o),
    .vec_last (vec_last),
    .eval_en  (eval_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear_x   = 1'b0;
    advance   = 1'b0;
    terminate = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      clear_x   = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            load      = 1'b1;
            state_nxt = SAMPLE;
          end
        end
        SAMPLE: begin
          if (eval_en) begin
            if (vec_last || ((STOP_ON_FAIL != 0) && !ok)) begin
              terminate = 1'b1;
              state_nxt = DONE;
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters and the counterexample survive abort so a cancelled run can still be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt  <= '0;
      cex_valid <= 1'b0;
      cex_x     <= '0;
      cex_y     <= '0;
      pass      <= 1'b0;
    end else if (abort) begin
      pass <= 1'b0;
    end else if (load) begin
      fail_cnt  <= '0;
      cex_valid <= 1'b0;
      cex_x     <= '0;
      cex_y     <= '0;
      pass      <= 1'b0;
    end else if (eval_en) begin
      if (!ok) begin
        fail_cnt <= fail_nxt;
        if (!cex_valid) begin
          cex_valid <= 1'b1;
          cex_x     <= x_o;
          cex_y     <= y_i;
        end
      end
      if (terminate) begin
        pass <= (fail_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - scoreboard bench for skolem_sweep_checker
module tb_skolem_sweep_checker;

  typedef struct {
    int         fails;
    bit         pass;
    bit         cexv;
    logic [5:0] cexx;
    logic [1:0] cexy;
    logic [5:0] last_x;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a [3];
  logic       abort_a [3];
  logic [5:0] x_a     [3];
  logic [1:0] y_a     [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic       pass_a  [3];
  logic [6:0] fc_a    [3];
  logic       cexv_a  [3];
  logic [5:0] cexx_a  [3];
  logic [1:0] cexy_a  [3];
  int         y_mode  [3];

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  skolem_sweep_checker #(.N_IN(6), .N_OUT(2), .SETTLE_CYCLES(1), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .abort(abort_a[0]), .x_o(x_a[0]), .y_i(y_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .fail_cnt(fc_a[0]),
    .cex_valid(cexv_a[0]), .cex_x(cexx_a[0]), .cex_y(cexy_a[0]));

  skolem_sweep_checker #(.N_IN(6), .N_OUT(2), .SETTLE_CYCLES(1), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .abort(abort_a[1]), .x_o(x_a[1]), .y_i(y_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .fail_cnt(fc_a[1]),
    .cex_valid(cexv_a[1]), .cex_x(cexx_a[1]), .cex_y(cexy_a[1]));

  skolem_sweep_checker #(.N_IN(6), .N_OUT(2), .SETTLE_CYCLES(3), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .abort(abort_a[2]), .x_o(x_a[2]), .y_i(y_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .fail_cnt(fc_a[2]),
    .cex_valid(cexv_a[2]), .cex_x(cexx_a[2]), .cex_y(cexy_a[2]));

  // Stand-in Skolem block: mode 0 correct, 1 stuck at 00, 2 stuck at 01
  function automatic logic [1:0] skolem_model(input int mode, input logic [5:0] x);
    case (mode)
      0:       return {1'b0, ~(^x)};
      1:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) y_a[k] = skolem_model(y_mode[k], x_a[k]);
  end

  function automatic exp_t predict(input int mode, input bit stop, input int settle);
    exp_t       e;
    logic [5:0] xv;
    logic [1:0] yv;
    int         ones, n;
    bit         good;
    e.fails = 0; e.pass = 1'b0; e.cexv = 1'b0; e.cexx = '0; e.cexy = '0; e.last_x = '0;
    n = 0;
    for (int x = 0; x < 64; x++) begin
      xv = 6'(x);
      yv = skolem_model(mode, xv);
      ones = 0;
      for (int b = 0; b < 6; b++) ones += int'(xv[b]);
      good = ((yv[0] ^ yv[1]) == ((ones % 2) == 0));
      n++;
      e.last_x = xv;
      if (!good) begin
        e.fails++;
        if (!e.cexv) begin
          e.cexv = 1'b1; e.cexx = xv; e.cexy = yv;
        end
        if (stop) break;
      end
    end
    e.lat  = n * settle;
    e.pass = (e.fails == 0);
    return e;
  endfunction

  // Pulses start, optionally re-pulses start mid-sweep, and measures the run until done.
  task automatic run_sweep(input int k, input int settle, input int restart_at,
                           output int lat, output int busy_cycles, output int xo_bad, output bit timeout);
    int cyc;
    @(negedge clk); start_a[k] = 1'b1;
    @(negedge clk); start_a[k] = 1'b0;
    cyc = 0; busy_cycles = busy_a[k] ? 1 : 0; xo_bad = (x_a[k] !== 6'd0) ? 1 : 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done_a[k]) break;
      start_a[k] = (cyc == restart_at);
      if (busy_a[k]) busy_cycles++;
      if (x_a[k] !== 6'(cyc / settle)) xo_bad++;
    end
    start_a[k] = 1'b0;
    lat = cyc;
    timeout = !done_a[k];
  endtask

  task automatic test_reset();
    checks++; if (x_a[0] !== 6'd0) begin errors++; $display("FAIL reset_x_o: got %h expected 00", x_a[0]); end
    checks++; if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || pass_a[0] !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b pass=%b expected 0 0 0", busy_a[0], done_a[0], pass_a[0]);
    end
    checks++; if (fc_a[0] !== 7'd0 || cexv_a[0] !== 1'b0 || cexx_a[0] !== 6'd0 || cexy_a[0] !== 2'd0) begin
      errors++; $display("FAIL reset_counters: fail_cnt=%0d cex_valid=%b cex_x=%h cex_y=%b expected zeros",
                         fc_a[0], cexv_a[0], cexx_a[0], cexy_a[0]);
    end
  endtask

  task automatic test_clean_sweep();
    exp_t e; int lat, bc, xb; bit to;
    y_mode[0] = 0;
    sb_q.push_back(predict(0, 1'b0, 1));
    run_sweep(0, 1, 10, lat, bc, xb, to);
    e = sb_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL clean_timeout: done not seen within 1000 cycles"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL clean_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (bc != e.lat) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected %0d", bc, e.lat); end
    checks++; if (xb != 0) begin errors++; $display("FAIL clean_x_step: %0d cycles with wrong x_o, expected 0", xb); end
    checks++; if (pass_a[0] !== e.pass) begin errors++; $display("FAIL clean_pass: got %b expected %b", pass_a[0], e.pass); end
    checks++; if (fc_a[0] !== 7'(e.fails)) begin errors++; $display("FAIL clean_fail_cnt: got %0d expected %0d", fc_a[0], e.fails); end
    checks++; if (cexv_a[0] !== e.cexv) begin errors++; $display("FAIL clean_cex_valid: got %b expected %b", cexv_a[0], e.cexv); end
    checks++; if (x_a[0] !== e.last_x) begin errors++; $display("FAIL clean_x_final: got %h expected %h", x_a[0], e.last_x); end
  endtask

  task automatic test_const_zero();
    exp_t e; int lat, bc, xb; bit to;
    y_mode[0] = 1;
    sb_q.push_back(predict(1, 1'b0, 1));
    run_sweep(0, 1, -1, lat, bc, xb, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != e.lat) begin errors++; $display("FAIL zero_latency: got %0d timeout=%b expected %0d", lat, to, e.lat); end
    checks++; if (fc_a[0] !== 7'(e.fails)) begin errors++; $display("FAIL zero_fail_cnt: got %0d expected %0d", fc_a[0], e.fails); end
    checks++; if (pass_a[0] !== e.pass) begin errors++; $display("FAIL zero_pass: got %b expected %b", pass_a[0], e.pass); end
    checks++; if (cexv_a[0] !== e.cexv || cexx_a[0] !== e.cexx || cexy_a[0] !== e.cexy) begin
      errors++; $display("FAIL zero_cex: got v=%b x=%h y=%b expected v=%b x=%h y=%b",
                         cexv_a[0], cexx_a[0], cexy_a[0], e.cexv, e.cexx, e.cexy);
    end
  endtask

  task automatic test_stop_on_fail();
    exp_t e; int lat, bc, xb; bit to;
    y_mode[1] = 2;
    sb_q.push_back(predict(2, 1'b1, 1));
    run_sweep(1, 1, -1, lat, bc, xb, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != e.lat) begin errors++; $display("FAIL stop_latency: got %0d timeout=%b expected %0d", lat, to, e.lat); end
    checks++; if (fc_a[1] !== 7'(e.fails)) begin errors++; $display("FAIL stop_fail_cnt: got %0d expected %0d", fc_a[1], e.fails); end
    checks++; if (cexv_a[1] !== e.cexv || cexx_a[1] !== e.cexx || cexy_a[1] !== e.cexy) begin
      errors++; $display("FAIL stop_cex: got v=%b x=%h y=%b expected v=%b x=%h y=%b",
                         cexv_a[1], cexx_a[1], cexy_a[1], e.cexv, e.cexx, e.cexy);
    end
    checks++; if (pass_a[1] !== e.pass || x_a[1] !== e.last_x) begin
      errors++; $display("FAIL stop_final: pass=%b x_o=%h expected pass=%b x_o=%h", pass_a[1], x_a[1], e.pass, e.last_x);
    end
  endtask

  task automatic test_settle3();
    exp_t e; int lat, bc, xb; bit to;
    y_mode[2] = 0;
    sb_q.push_back(predict(0, 1'b0, 3));
    run_sweep(2, 3, -1, lat, bc, xb, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != e.lat) begin errors++; $display("FAIL settle3_latency: got %0d timeout=%b expected %0d", lat, to, e.lat); end
    checks++; if (xb != 0) begin errors++; $display("FAIL settle3_x_step: %0d cycles with wrong x_o, expected 0", xb); end
    checks++; if (pass_a[2] !== e.pass || fc_a[2] !== 7'(e.fails)) begin
      errors++; $display("FAIL settle3_result: pass=%b fail_cnt=%0d expected pass=%b fail_cnt=%0d", pass_a[2], fc_a[2], e.pass, e.fails);
    end
  endtask

  task automatic test_abort();
    int cyc;
    y_mode[0] = 0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    cyc = 0;
    while (x_a[0] !== 6'h0A && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (x_a[0] !== 6'h0A) begin errors++; $display("FAIL abort_reach: x_o=%h expected 0a", x_a[0]); end
    abort_a[0] = 1'b1;
    @(negedge clk); abort_a[0] = 1'b0;
    checks++; if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || x_a[0] !== 6'd0) begin
      errors++; $display("FAIL abort_idle: busy=%b done=%b x_o=%h expected 0 0 00", busy_a[0], done_a[0], x_a[0]);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy_a[0] !== 1'b0 || x_a[0] !== 6'd0) begin
      errors++; $display("FAIL abort_stays_idle: busy=%b x_o=%h expected 0 00", busy_a[0], x_a[0]);
    end
    test_clean_sweep();
  endtask

  task automatic test_reset_mid();
    int cyc; int done_seen;
    y_mode[0] = 0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    cyc = 0;
    while (x_a[0] !== 6'h20 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (x_a[0] !== 6'h20) begin errors++; $display("FAIL rst_reach: x_o=%h expected 20", x_a[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x_a[0] !== 6'd0 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || fc_a[0] !== 7'd0 ||
                  cexv_a[0] !== 1'b0 || pass_a[0] !== 1'b0) begin
      errors++; $display("FAIL rst_async: x_o=%h busy=%b done=%b fail_cnt=%0d cex_valid=%b pass=%b expected all zero",
                         x_a[0], busy_a[0], done_a[0], fc_a[0], cexv_a[0], pass_a[0]);
    end
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (done_a[0]) done_seen++; end
    rst_n = 1'b1;
    repeat (70) begin @(negedge clk); if (done_a[0] || busy_a[0]) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_no_done: %0d cycles with done/busy, expected 0", done_seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0; abort_a[k] = 1'b0; y_mode[k] = 0;
    end
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_clean_sweep();
    test_const_zero();
    test_stop_on_fail();
    test_settle3();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skolem_sweep_checker.md
Name: skolem_sweep_checker

Overview:
- Sequential verification stage that sits directly downstream of a synthesized combinational Skolem function block for the xor_6_2 benchmark (6 universal inputs, 2 existential outputs).
- Exhaustively drives every 2^N_IN input assignment into the Skolem block and samples its returned outputs.
- Evaluates the specification formula on each (x, y) pair, counts violations and captures the first counterexample.
- Used in the bnsynth flow to certify generated Skolem functions in simulation or on FPGA.

Parameters:
- N_IN, 6: number of universal inputs; width of x_o.
- N_OUT, 2: number of Skolem outputs; width of y_i. Fixed at 2 for the xor spec.
- SETTLE_CYCLES, 1: cycles between driving x_o and sampling y_i. Legal range 1..15.
- STOP_ON_FAIL, 0: 1 = terminate the sweep at the first violation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep; accepted only in IDLE or DONE
- abort  in  1  synchronous cancel; returns to IDLE
- x_o  out  N_IN  current input assignment driven to the Skolem block
- y_i  in  N_OUT  Skolem block outputs for x_o (combinational return)
- busy  out  1  high in SAMPLE
- done  out  1  high in DONE; held until the next start or abort
- pass  out  1  valid while done is high; equals (fail_cnt == 0)
- fail_cnt  out  N_IN+1  number of violating assignments
- cex_valid  out  1  at least one violation captured
- cex_x  out  N_IN  first violating x
- cex_y  out  N_OUT  y returned at the first violation

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - x_o, fail_cnt, cex_x and cex_y go to 0.
  - busy, done, pass and cex_valid go to 0.
  - settle_cnt goes to 0.
- Spec predicate: ok = ((y_i[0] ^ y_i[1]) == ~(^x_o)).
- FSM states: IDLE, SAMPLE, DONE.
- IDLE/DONE with start high (and abort low):
  - x_o <= 0; fail_cnt <= 0; cex_valid <= 0; cex_x/cex_y <= 0.
  - settle_cnt <= SETTLE_CYCLES-1; done <= 0; next state SAMPLE.
- SAMPLE with settle_cnt != 0: decrement settle_cnt; x_o is held.
- SAMPLE with settle_cnt == 0 (evaluation edge):
  - If !ok: fail_cnt <= fail_cnt+1. If cex_valid is 0, capture cex_x <= x_o, cex_y <= y_i, cex_valid <= 1.
  - If x_o is all-ones, or (STOP_ON_FAIL and !ok): next state DONE. x_o holds its last value.
  - Otherwise: x_o <= x_o+1; settle_cnt <= SETTLE_CYCLES-1.
- Full-sweep latency: done rises 2^N_IN * SETTLE_CYCLES cycles after the start edge (64 for defaults).
- fail_cnt saturation: cannot overflow, because its maximum value 2^N_IN fits in N_IN+1 bits. x_o never wraps; the all-ones value terminates the sweep.
- abort in any state: next state IDLE, x_o <= 0, busy/done <= 0. Counters and cex fields keep their values for debug.
- Priority: abort beats start. start while in SAMPLE is ignored.
- pass is registered, and updates on entry to DONE.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Decomposition:
- Shared package skolem_chk_pkg holds:
  - state enum (IDLE, SAMPLE, DONE);
  - function spec_xor_ok(x, y) implementing the predicate;
  - localparam NUM_VEC = 2**N_IN.
- One sub-module is natural: skolem_vec_gen, the x_o counter plus settle_cnt. It exposes vec_last and eval_en to the FSM.
- Predicate evaluation and counters stay in the top module.

Test Plan:
- Correct Skolem model (defaults) in the loop, pulse start → busy for 64 cycles, done=1, pass=1, fail_cnt=0, cex_valid=0, x_o=6'h3F.
- y_i tied to 2'b00 → fail_cnt=32, pass=0, cex_valid=1, cex_x=6'h00, cex_y=2'b00, done 64 cycles after start.
- STOP_ON_FAIL=1, y_i tied to 2'b01 → first violation at x=6'h01; done 2 cycles after start, fail_cnt=1, cex_x=6'h01, cex_y=2'b01.
- SETTLE_CYCLES=3 with the correct model → x_o advances every 3 cycles; done at cycle 192; pass=1.
- abort asserted when x_o=6'h0A → next cycle state IDLE, busy=0, done=0, x_o=0. A following start runs a full clean sweep.
- rst_n pulsed low mid-sweep (x_o=6'h20), asynchronously between edges → outputs reach reset values immediately without a clock edge, and no done is asserted.
